lcd_text_sequencer: RTL and testbench
=====================================

# lcd_text_sequencer

Sequences a full 2×16 character refresh of the character LCD through the LCD driver's DATA/OPER/ENB/RDY command port. It holds a 32-byte frame buffer that the temperature formatter writes asynchronously to refreshes. On each refresh request it issues the DDRAM-address instructions and the 32 character writes in order, one transaction per driver RDY handshake. A watchdog flags a driver that stops acknowledging.

## Interface
Parameters:
- ACK_TIMEOUT, 1024: maximum cycles to wait for LCD_RDY to fall after an ENB pulse, and again to rise after it falls.
- TW, 16: watchdog counter width. ACK_TIMEOUT must be < 2^TW.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high; clock CLK
- BUF_WE  in  1  frame-buffer write strobe
- BUF_ADDR  in  5  buffer address: 0–15 line 1, 16–31 line 2
- BUF_WDATA  in  8  character code
- REFRESH  in  1  refresh request, sampled every cycle
- BUSY  out  1  refresh in progress
- DONE  out  1  one-cycle pulse after the last character is accepted
- ERR  out  1  sticky watchdog error
- LCD_RDY  in  1  driver idle/ready
- LCD_DATA  out  8  to driver DATA
- LCD_OPER  out  2  to driver OPER: 1 = character, 2 = instruction
- LCD_ENB  out  1  to driver ENB, one-cycle pulse

## Operation
- **Reset values:** BUSY=0, DONE=0, ERR=0, LCD_ENB=0, LCD_OPER=0, LCD_DATA=0x00. All 32 buffer entries = 0x20. Pending flag = 0. State = IDLE.
- **Buffer writes:**
  - Accepted every cycle, including during a refresh.
  - BUF_WDATA < 0x20 or > 0x7E is stored as 0x20.
  - A write to an entry not yet issued in the current refresh is displayed by that refresh.
- **Transaction list** (index k = 0..33):
  - k=0: instruction 0x80.
  - k=1..16: character buf[k-1].
  - k=17: instruction 0xC0.
  - k=18..33: character buf[k-2].
  - The character is read from the buffer in the ISSUE cycle.
- **States:**
  - IDLE: REFRESH=1 or pending=1 → k=0, clear ERR and pending, set BUSY, go to WAIT_RDY.
  - WAIT_RDY: LCD_RDY=1 → ISSUE.
  - ISSUE: drive DATA/OPER and LCD_ENB=1 for exactly this cycle, clear watchdog → WAIT_ACK.
  - WAIT_ACK: LCD_RDY=0 → WAIT_DONE, clear watchdog. Watchdog reaching ACK_TIMEOUT → ABORT.
  - WAIT_DONE: LCD_RDY=1 → if k=33 go to FINISH, else k+1 and go to ISSUE. Watchdog reaching ACK_TIMEOUT → ABORT.
  - FINISH: DONE=1 for one cycle, BUSY=0 → IDLE.
  - ABORT: ERR=1, BUSY=0, DONE stays 0, pending cleared → IDLE.
- **LCD_DATA/LCD_OPER:** hold their last issued values between transactions. LCD_ENB is 0 outside ISSUE.
- **REFRESH while BUSY:** sets pending (one level deep; further requests are merged). Serviced immediately after FINISH.
- **REFRESH in the same cycle as FINISH:** sets pending.
- **RST mid-refresh:** everything returns to reset values on the next edge, including buffer contents. No further ENB pulses.
- **Watchdog:** saturating counter of width TW.

## Timing
- REFRESH sampled at edge t in IDLE with LCD_RDY=1: BUSY=1 after edge t. First LCD_ENB high in the cycle after edge t+1.
- Per transaction: 1 ISSUE cycle, plus the driver's busy time, plus 1 cycle to detect RDY rising.
- Minimum total: 34 × (ISSUE + ≥1 ack cycle + ≥1 done cycle) + 2 cycles.
- DONE asserts the cycle after the 34th RDY rise is sampled.
- ERR asserts the cycle after the watchdog count equals ACK_TIMEOUT.

## Structure
- **Package `lcd_seq_pkg`:**
  - OPER codes: OPER_IDLE=0, OPER_CHAR=1, OPER_INSTR=2, OPER_RESET=3.
  - Line addresses: DDRAM_L1=0x80, DDRAM_L2=0xC0.
  - Constants: SPACE=0x20, N_XACT=34.
  - State enum.
- **Sub-module `lcd_frame_buf`:** 32×8 register file with synchronous write, combinational read port, reset to SPACE, and the printable-range clamp on write.
- The FSM, index counter, watchdog and pending flag live in the top module.

## Test plan
- **Normal refresh.** Driver model holds RDY low for 5 cycles per command. Pulse REFRESH. Expect 34 ENB pulses in order: 0x80/OPER2, then "0123456789ABCDEF" chars/OPER1, then 0xC0/OPER2, then 16 chars. One DONE pulse; BUSY falls with DONE.
- **Buffer clamp.** Write 0x0A to addr 3 and 0x7F to addr 20, then refresh. Expect LCD_DATA=0x20 at k=4 and k=22.
- **Pending merge.** Pulse REFRESH three times while BUSY. Expect exactly two complete 34-transaction refreshes and two DONE pulses.
- **Watchdog.** Driver never drops RDY after ENB. Expect ERR=1 exactly ACK_TIMEOUT+1 cycles after the ENB pulse, BUSY=0, no DONE. A subsequent REFRESH clears ERR.
- **Mid-refresh reset.** Assert RST during k=10. Expect all outputs at reset values the next cycle, no ENB afterwards, and buffer reads 0x20 on the next refresh.
- **Write during refresh.** Write 'Z' to addr 30 while k=5. Expect 'Z' issued at k=32.

Source files
------------

// File: rtl/lcd_text_sequencer_pkg.sv
// Shared constants, state encoding and the printable-character clamp for the
// LCD text sequencer.
package lcd_seq_pkg;

  localparam logic [1:0] OPER_IDLE  = 2'd0;
  localparam logic [1:0] OPER_CHAR  = 2'd1;
  localparam logic [1:0] OPER_INSTR = 2'd2;
  localparam logic [1:0] OPER_RESET = 2'd3;

  localparam logic [7:0] DDRAM_L1 = 8'h80;
  localparam logic [7:0] DDRAM_L2 = 8'hC0;
  localparam logic [7:0] SPACE    = 8'h20;
  localparam int         N_XACT   = 34;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_FINISH,
    ST_ABORT
  } state_e;

  // Anything outside the LCD's printable ASCII range is shown as a blank.
  function automatic logic [7:0] clamp_char(input logic [7:0] c);
    return ((c < 8'h20) || (c > 8'h7E)) ? SPACE : c;
  endfunction

endpackage

// File: rtl/lcd_text_sequencer_if.sv
// Host-side frame-buffer/refresh port plus the LCD driver command port.
interface lcd_text_sequencer_if;
  import lcd_seq_pkg::*;

  logic       BUF_WE;
  logic [4:0] BUF_ADDR;
  logic [7:0] BUF_WDATA;
  logic       REFRESH;
  logic       BUSY;
  logic       DONE;
  logic       ERR;
  logic       LCD_RDY;
  logic [7:0] LCD_DATA;
  logic [1:0] LCD_OPER;
  logic       LCD_ENB;

  modport master (
    output BUF_WE, BUF_ADDR, BUF_WDATA, REFRESH, LCD_RDY,
    input  BUSY, DONE, ERR, LCD_DATA, LCD_OPER, LCD_ENB
  );

  modport slave (
    input  BUF_WE, BUF_ADDR, BUF_WDATA, REFRESH, LCD_RDY,
    output BUSY, DONE, ERR, LCD_DATA, LCD_OPER, LCD_ENB
  );

endinterface

// File: rtl/lcd_text_sequencer_frame_buf.sv
// 32-entry character frame buffer: clamped synchronous write, combinational read.
module lcd_frame_buf
  import lcd_seq_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       we_i,
  input  logic [4:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic [4:0] rd_addr_i,
  output logic [7:0] rd_data_o
);

  logic [7:0] mem_q [32];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= SPACE;
    end else if (we_i) begin
      mem_q[addr_i] <= clamp_char(wdata_i);
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/lcd_text_sequencer.sv
// Issues the 34-transaction 2x16 LCD refresh (two DDRAM address instructions
// and 32 characters) with a per-phase acknowledge watchdog and one-deep request merge.
module lcd_text_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1024,
  parameter int TW          = 16
) (
  input logic           CLK,
  input logic           RST,
  lcd_text_sequencer_if.slave bus
);

  localparam logic [TW-1:0] WD_LIM = TW'(ACK_TIMEOUT);
  localparam logic [5:0]    K_LAST = 6'(N_XACT - 1);
  localparam logic [5:0]    K_L2   = 6'd17;

  state_e        state_q;
  logic [5:0]    k_q, k_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          pend_q, busy_q, done_q, err_q, enb_q;
  logic [7:0]    data_q;
  logic [1:0]    oper_q;

  logic [4:0]    rd_addr;
  logic [7:0]    rd_data, buf_char, xact_data;
  logic [1:0]    xact_oper;
  logic          wd_hit;

  lcd_frame_buf u_buf (
    .CLK       (CLK),
    .RST       (RST),
    .we_i      (bus.BUF_WE),
    .addr_i    (bus.BUF_ADDR),
    .wdata_i   (bus.BUF_WDATA),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Outputs are registered on entry to ISSUE, so the transaction is decoded
  // one cycle early; the write bypass keeps a same-cycle buffer write visible.
  always_comb begin
    k_d      = (state_q == ST_WAIT_DONE) ? k_q + 6'd1 : k_q;
    rd_addr  = k_d[4:0] - ((k_d < K_L2) ? 5'd1 : 5'd2);
    buf_char = (bus.BUF_WE && (bus.BUF_ADDR == rd_addr)) ? clamp_char(bus.BUF_WDATA)
                                                         : rd_data;
    if (k_d == 6'd0) begin
      xact_data = DDRAM_L1;
      xact_oper = OPER_INSTR;
    end else if (k_d == K_L2) begin
      xact_data = DDRAM_L2;
      xact_oper = OPER_INSTR;
    end else begin
      xact_data = buf_char;
      xact_oper = OPER_CHAR;
    end
    wd_d   = (wd_q == '1) ? wd_q : wd_q + TW'(1);
    wd_hit = (wd_q == WD_LIM);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      wd_q    <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      enb_q   <= 1'b0;
      data_q  <= 8'h00;
      oper_q  <= OPER_IDLE;
    end else begin
      enb_q  <= 1'b0;
      done_q <= 1'b0;
      if (bus.REFRESH && (state_q != ST_IDLE)) pend_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (bus.REFRESH || pend_q) begin
            k_q     <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (bus.LCD_RDY) begin
            enb_q   <= 1'b1;
            data_q  <= xact_data;
            oper_q  <= xact_oper;
            wd_q    <= '0;
            state_q <= ST_ISSUE;
          end
        end
        // The watchdog already runs during the ENB cycle itself.
        ST_ISSUE: begin
          wd_q    <= wd_d;
          state_q <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (!bus.LCD_RDY) begin
            wd_q    <= '0;
            state_q <= ST_WAIT_DONE;
          end else if (wd_hit) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_ABORT;
          end else begin
            wd_q <= wd_d;
          end
        end
        ST_WAIT_DONE: begin
          if (bus.LCD_RDY) begin
            if (k_q == K_LAST) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_FINISH;
            end else begin
              k_q     <= k_d;
              enb_q   <= 1'b1;
              data_q  <= xact_data;
              oper_q  <= xact_oper;
              wd_q    <= '0;
              state_q <= ST_ISSUE;
            end
          end else if (wd_hit) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_ABORT;
          end else begin
            wd_q <= wd_d;
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        ST_ABORT: begin
          pend_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.ERR      = err_q;
  assign bus.LCD_ENB  = enb_q;
  assign bus.LCD_DATA = data_q;
  assign bus.LCD_OPER = oper_q;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Bench for lcd_text_sequencer: table-loaded frame buffer, scoreboard of
// expected LCD transactions, and a simple RDY-handshake driver model.
module tb_lcd_text_sequencer;

  localparam int T = 20;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] oper;
  } xact_t;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;

  lcd_text_sequencer_if bus();

  lcd_text_sequencer #(.ACK_TIMEOUT(T), .TW(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int         checks = 0;
  int         errors = 0;
  int         enb_total = 0;
  int         done_cnt = 0;
  bit         hang = 1'b0;
  bit         m_pend = 1'b0;
  xact_t      exp_q[$];
  logic [7:0] mbuf[32];
  vec_t       tbl[32];
  string      s1 = "0123456789ABCDEF";
  logic [7:0] w2[16] = '{8'h1F, 8'h20, 8'h7E, 8'h7F, 8'h00, 8'hFF, 8'h80, 8'h21,
                         8'h54, 8'h3D, 8'h32, 8'h33, 8'h2E, 8'h35, 8'h43, 8'h21};
  logic [7:0] e2[16] = '{8'h20, 8'h20, 8'h7E, 8'h20, 8'h20, 8'h20, 8'h20, 8'h21,
                         8'h54, 8'h3D, 8'h32, 8'h33, 8'h2E, 8'h35, 8'h43, 8'h21};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver model: RDY drops the edge after an ENB and stays low busy_cyc cycles.
  initial begin
    bus.LCD_RDY = 1'b1;
    forever begin
      @(negedge CLK);
      if (bus.LCD_ENB === 1'b1 && !hang) begin
        @(posedge CLK);
        #1 bus.LCD_RDY = 1'b0;
        repeat (5) @(posedge CLK);
        #1 bus.LCD_RDY = 1'b1;
      end
    end
  end

  always @(negedge CLK) begin : monitor
    xact_t e;
    if (bus.LCD_ENB === 1'b1) begin
      enb_total++;
      if (exp_q.size() == 0) begin
        chk("enb_with_empty_queue", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("xact#%0d oper,data", enb_total), {bus.LCD_OPER, bus.LCD_DATA},
            {e.oper, e.data});
      end
    end
    if (bus.DONE === 1'b1) begin
      done_cnt++;
      chk("busy_low_with_done", bus.BUSY, 0);
    end
  end

  task automatic write_buf(input logic [4:0] a, input logic [7:0] d);
    bus.BUF_WE    = 1'b1;
    bus.BUF_ADDR  = a;
    bus.BUF_WDATA = d;
    @(negedge CLK);
    bus.BUF_WE    = 1'b0;
  endtask

  task automatic push_frame();
    exp_q.push_back('{data: 8'h80, oper: 2'd2});
    for (int i = 0; i < 16; i++) exp_q.push_back('{data: mbuf[i], oper: 2'd1});
    exp_q.push_back('{data: 8'hC0, oper: 2'd2});
    for (int i = 16; i < 32; i++) exp_q.push_back('{data: mbuf[i], oper: 2'd1});
  endtask

  task automatic pulse_refresh();
    bus.REFRESH = 1'b1;
    @(negedge CLK);
    bus.REFRESH = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(name, done_cnt, target);
  endtask

  task automatic wait_enbs(input int n, input int budget, input string name);
    int seen = 0;
    int c = 0;
    while (seen < n && c < budget) begin
      @(negedge CLK);
      c++;
      if (bus.LCD_ENB === 1'b1) seen++;
    end
    chk(name, seen, n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, bus.BUSY, 0);
    chk({tag, "_done"}, bus.DONE, 0);
    chk({tag, "_err"},  bus.ERR, 0);
    chk({tag, "_enb"},  bus.LCD_ENB, 0);
    chk({tag, "_oper"}, bus.LCD_OPER, 0);
    chk({tag, "_data"}, bus.LCD_DATA, 0);
  endtask

  initial begin : global_timeout
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : main
    int base;
    int eb;
    int n;

    RST = 1'b1;
    bus.BUF_WE = 1'b0;
    bus.BUF_ADDR = '0;
    bus.BUF_WDATA = '0;
    bus.REFRESH = 1'b0;
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    for (int i = 0; i < 16; i++) begin
      tbl[i]      = '{addr: 5'(i), wdata: s1[i], exp: s1[i]};
      tbl[16 + i] = '{addr: 5'(16 + i), wdata: w2[i], exp: e2[i]};
    end

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk_reset_outputs("reset");

    // Normal refresh with table-loaded buffer contents
    for (int i = 0; i < 32; i++) begin
      write_buf(tbl[i].addr, tbl[i].wdata);
      mbuf[tbl[i].addr] = tbl[i].exp;
    end
    push_frame();
    base = done_cnt;
    pulse_refresh();
    chk("busy_after_refresh", bus.BUSY, 1);
    chk("enb_low_before_issue", bus.LCD_ENB, 0);
    @(negedge CLK);
    chk("first_enb_timing", bus.LCD_ENB, 1);
    wait_done(base + 1, 1000, "normal_done");
    chk("normal_queue_drained", exp_q.size(), 0);
    repeat (5) @(negedge CLK);
    chk("normal_single_done", done_cnt, base + 1);
    chk("normal_busy_idle", bus.BUSY, 0);

    // Clamp on write
    write_buf(5'd3, 8'h0A);
    mbuf[3] = 8'h20;
    write_buf(5'd20, 8'h7F);
    mbuf[20] = 8'h20;
    push_frame();
    base = done_cnt;
    pulse_refresh();
    wait_done(base + 1, 1000, "clamp_done");

    // Three requests while busy merge into a single extra refresh
    repeat (3) @(negedge CLK);
    eb = enb_total;
    base = done_cnt;
    push_frame();
    pulse_refresh();
    m_pend = 1'b0;
    for (int r = 0; r < 3; r++) begin
      repeat (20) @(negedge CLK);
      chk("busy_during_merge", bus.BUSY, 1);
      if (!m_pend) begin
        push_frame();
        m_pend = 1'b1;
      end
      pulse_refresh();
    end
    wait_done(base + 2, 2500, "merge_two_done");
    repeat (50) @(negedge CLK);
    chk("merge_done_count", done_cnt, base + 2);
    chk("merge_enb_count", enb_total - eb, 68);
    chk("merge_queue_drained", exp_q.size(), 0);

    // Write to a not-yet-issued entry during a refresh
    push_frame();
    base = done_cnt;
    pulse_refresh();
    wait_enbs(6, 200, "reach_k5");
    exp_q[exp_q.size() - 2] = '{data: 8'h5A, oper: 2'd1};
    mbuf[30] = 8'h5A;
    write_buf(5'd30, 8'h5A);
    wait_done(base + 1, 1000, "write_during_done");

    // Watchdog: driver never acknowledges
    repeat (3) @(negedge CLK);
    hang = 1'b1;
    exp_q.push_back('{data: 8'h80, oper: 2'd2});
    base = done_cnt;
    pulse_refresh();
    wait_enbs(1, 20, "wd_first_enb");
    n = 0;
    while (bus.ERR !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("wd_err_latency", n, T + 1);
    chk("wd_busy_low", bus.BUSY, 0);
    repeat (5) @(negedge CLK);
    chk("wd_err_sticky", bus.ERR, 1);
    chk("wd_no_done", done_cnt, base);
    hang = 1'b0;
    push_frame();
    pulse_refresh();
    chk("wd_err_cleared", bus.ERR, 0);
    wait_done(base + 1, 1000, "wd_recover_done");

    // Reset in the middle of a refresh
    repeat (3) @(negedge CLK);
    push_frame();
    pulse_refresh();
    wait_enbs(11, 300, "reach_k10");
    RST = 1'b1;
    @(negedge CLK);
    chk_reset_outputs("midrst");
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    eb = enb_total;
    repeat (40) @(negedge CLK);
    chk("midrst_no_enb", enb_total - eb, 0);
    push_frame();
    base = done_cnt;
    pulse_refresh();
    wait_done(base + 1, 1000, "post_reset_done");
    chk("post_reset_queue_drained", exp_q.size(), 0);

    repeat (5) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
